pixel_cmd_decoder: RTL
======================

// Module: pixel_cmd_decoder
// PURPOSE
//  Consumer end of the CPU pixel_data PIO. Samples the 32-bit word the CPU writes to that port,
//  detects a new word through a toggle bit, and decodes it into framebuffer writes.
//  Writes go out as an Avalon-MM write master to the VGA framebuffer RAM/arbiter.
//  Returns handshake and status bits to the CPU through a status PIO input port.
// PARAMETERS
//  H_RES    640  visible pixels per line
//  V_RES    480  visible lines
//  ADDR_W   19   framebuffer word address width (H_RES*V_RES <= 2**ADDR_W)
//  COLOR_W  12   pixel colour width (RGB444)
// PORTS
//  clk             in   1        system clock (same domain as the PIO; no synchroniser needed)
//  reset_n         in   1        asynchronous, active-low reset
//  cmd_word        in   32       pixel_data PIO out_port value
//  fb_addr         out  ADDR_W   framebuffer write address (linear, y*H_RES+x)
//  fb_wdata        out  COLOR_W  framebuffer write data
//  fb_write        out  1        Avalon write request
//  fb_waitrequest  in   1        Avalon stall; a write completes on a clk edge with fb_write=1, waitrequest=0
//  status          out  8        [0] busy, [1] overrun (sticky), [2] range_err (sticky), [3] ack_tog, [7:4] 0
// BEHAVIOUR
//  Word format: [31] tog, [30:29] op, [28] reserved (ignored).
//   op 00 SET_XY: [18:10] y, [9:0] x.
//   op 01 WRITE: [COLOR_W-1:0] colour. Writes one pixel at the cursor, then advances the cursor.
//   op 10 FILL: [27:12] count (16 b), [COLOR_W-1:0] colour. Writes count pixels from the cursor.
//   op 11 CTRL: bit0=1 clears the overrun and range_err flags; other bits ignored.
//  Reset values: state=IDLE, last_tog=0, cursor x=y=0, lin_addr=0.
//   fb_write=0, fb_addr=0, fb_wdata=0, status=8'h00.
//   The PIO also resets to 0, so no spurious command is seen after reset.
//  New-word detection: a word is new in IDLE when cmd_word[31] != last_tog at a clk edge.
//   On that edge: latch the word, last_tog <= cmd_word[31], leave IDLE.
//   busy=1 and ack_tog=new tog are visible on the following cycle.
//  FSM states: IDLE, SETXY, WR, FILL.
//   SETXY: one cycle. If x<H_RES and y<V_RES, load the cursor and lin_addr=y*H_RES+x
//    (constant multiply, shift-add allowed). Otherwise leave the cursor unchanged and set range_err.
//    Then -> IDLE.
//   WR: fb_write=1 from the cycle after capture, with addr=lin_addr and data=colour.
//    Hold addr, data and write stable while fb_waitrequest=1.
//    On acceptance, advance the cursor and go -> IDLE (fb_write=0 next cycle).
//   FILL: same handshake per pixel, with remaining-count register rem=count.
//    Each accepted write does rem-1 and advances the cursor.
//    fb_write stays 1 back-to-back, giving 1 pixel/clk when there is no waitrequest.
//    -> IDLE on the edge accepting the write with rem==1. count==0 -> IDLE after 1 cycle, no writes.
//   CTRL: handled in the capture edge itself. The flags are cleared and the FSM stays IDLE.
//    busy is never asserted for CTRL.
//  Cursor advance: x+1 and lin_addr+1.
//   If x==H_RES-1: x=0 and y+1.
//   If additionally y==V_RES-1: y=0 and lin_addr=0 (frame wrap).
//  busy=1 in any state other than IDLE. It drops the cycle after the last accepted write.
//  Overrun: if tog changes while not IDLE, the word is dropped.
//   On that edge: overrun<=1, last_tog and ack_tog updated.
//   This means the word is not re-executed on return to IDLE.
//  Simultaneous events:
//   - tog changes on the same edge the FSM returns to IDLE: counts as overrun, word dropped.
//   - A CTRL clear and a flag-setting event cannot coincide. The flags are only set while busy,
//     and CTRL is only decoded in IDLE.
//  Reset mid-operation: asynchronously returns everything to its reset values.
//   fb_write drops immediately. The remaining FILL pixels are discarded.
// STRUCTURE
//  Shared package (vga_pkg): H_RES, V_RES, op encodings OP_SETXY/OP_WRITE/OP_FILL/OP_CTRL,
//   status bit indices, and the state enum.
//  One sub-module: pixel_cursor. It holds x, y and lin_addr, with inputs load/advance
//   and outputs for the wrap logic. The FSM, the word latch and the flags stay in the top module.
// TESTING
//  1. After reset: status=00, fb_write=0.
//     Drive cmd_word=32'h0000_0000 for 10 clk: no write, status stays 00.
//  2. SET_XY x=5 y=2 (tog=1), then WRITE colour 12'hF00 (tog=0):
//     exactly one write with fb_addr=1285 and fb_wdata=F00. ack_tog follows tog each time.
//  3. SET_XY x=638 y=479, then FILL count=4 colour 0AB, with waitrequest=0:
//     4 consecutive write cycles at addr 307198, 307199, 0, 1. busy is high for exactly 5 cycles.
//  4. WRITE while waitrequest is held high for 3 cycles:
//     fb_addr, fb_wdata and fb_write stay stable; one write is accepted on the 4th edge.
//  5. Toggle tog during a FILL of 100: overrun=1, no extra writes, the FILL completes.
//     Then CTRL bit0=1: status[2:1]=0.
//     SET_XY x=640 y=0: range_err=1, the next WRITE uses the old cursor.
//  6. Assert reset_n low mid-FILL: fb_write=0 with no clk edge.
//     After release, a WRITE goes to addr 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel command path: frame geometry,
// command opcodes, status bit positions and the decoder state encoding.
package vga_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 12;

    // Field widths fixed by the command word layout.
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        OP_SETXY = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_CTRL  = 2'b11
    } op_t;

    localparam int ST_BUSY      = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_RANGE_ERR = 2;
    localparam int ST_ACK_TOG   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETXY = 2'b01,
        WR    = 2'b10,
        FILL  = 2'b11
    } state_t;

    function automatic logic xy_in_frame(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int             hres,
        input int             vres
    );
        return (32'(x) < 32'(hres)) && (32'(y) < 32'(vres));
    endfunction

endpackage

// File: rtl/pixel_cursor.sv
// Framebuffer write cursor: x/y position plus the matching linear address,
// loadable from a SET_XY command and advanced after each accepted pixel.
module pixel_cursor
    import vga_pkg::*;
#(
    parameter int H_RES  = vga_pkg::H_RES,
    parameter int V_RES  = vga_pkg::V_RES,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [X_W-1:0]    load_x,
    input  logic [Y_W-1:0]    load_y,
    input  logic              advance,
    output logic [ADDR_W-1:0] lin_addr
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    logic [X_W-1:0]    x_reg;
    logic [Y_W-1:0]    y_reg;
    logic [ADDR_W-1:0] lin_addr_reg;
    logic              line_end;
    logic              frame_end;
    logic [ADDR_W-1:0] load_addr;

    assign line_end  = (x_reg == X_LAST);
    assign frame_end = line_end && (y_reg == Y_LAST);

    // Constant multiply; synthesis folds this into shift-add terms.
    assign load_addr = ADDR_W'(load_y) * ADDR_W'(H_RES) + ADDR_W'(load_x);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_reg        <= '0;
            y_reg        <= '0;
            lin_addr_reg <= '0;
        end else if (load) begin
            x_reg        <= load_x;
            y_reg        <= load_y;
            lin_addr_reg <= load_addr;
        end else if (advance) begin
            if (frame_end) begin
                x_reg        <= '0;
                y_reg        <= '0;
                lin_addr_reg <= '0;
            end else if (line_end) begin
                x_reg        <= '0;
                y_reg        <= y_reg + Y_W'(1);
                lin_addr_reg <= lin_addr_reg + ADDR_W'(1);
            end else begin
                x_reg        <= x_reg + X_W'(1);
                lin_addr_reg <= lin_addr_reg + ADDR_W'(1);
            end
        end
    end

    assign lin_addr = lin_addr_reg;

endmodule

// File: rtl/pixel_cmd_decoder.sv
// Decodes CPU pixel commands (toggle-flagged PIO words) into Avalon-MM
// framebuffer writes and reports busy/overrun/range status back to the CPU.
module pixel_cmd_decoder
    import vga_pkg::*;
#(
    parameter int H_RES   = vga_pkg::H_RES,
    parameter int V_RES   = vga_pkg::V_RES,
    parameter int ADDR_W  = vga_pkg::ADDR_W,
    parameter int COLOR_W = vga_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        cmd_word,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_wdata,
    output logic               fb_write,
    input  logic               fb_waitrequest,
    output logic [7:0]         status
);

    state_t             state_reg;
    logic               last_tog_reg;
    logic               overrun_reg;
    logic               range_err_reg;
    logic               fb_write_reg;
    logic [COLOR_W-1:0] fb_wdata_reg;
    logic [CNT_W-1:0]   rem_reg;
    logic [X_W-1:0]     set_x_reg;
    logic [Y_W-1:0]     set_y_reg;

    logic               new_tog;
    op_t                cmd_op;
    logic               accept;
    logic               xy_ok;
    logic               cursor_load;
    logic               unused_reserved;

    assign new_tog         = (cmd_word[31] != last_tog_reg);
    assign cmd_op          = op_t'(cmd_word[30:29]);
    assign accept          = fb_write_reg && !fb_waitrequest;
    assign xy_ok           = xy_in_frame(set_x_reg, set_y_reg, H_RES, V_RES);
    assign cursor_load     = (state_reg == SETXY) && xy_ok;
    assign unused_reserved = cmd_word[28];

    pixel_cursor #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cursor_load),
        .load_x   (set_x_reg),
        .load_y   (set_y_reg),
        .advance  (accept),
        .lin_addr (fb_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            last_tog_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            range_err_reg <= 1'b0;
            fb_write_reg  <= 1'b0;
            fb_wdata_reg  <= '0;
            rem_reg       <= '0;
            set_x_reg     <= '0;
            set_y_reg     <= '0;
        end else begin
            // A word arriving while busy is acknowledged but never executed.
            if (state_reg != IDLE && new_tog) begin
                last_tog_reg <= cmd_word[31];
                overrun_reg  <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (new_tog) begin
                        last_tog_reg <= cmd_word[31];
                        case (cmd_op)
                            OP_SETXY: begin
                                set_x_reg <= cmd_word[X_W-1:0];
                                set_y_reg <= cmd_word[X_W+Y_W-1:X_W];
                                state_reg <= SETXY;
                            end
                            OP_WRITE: begin
                                fb_wdata_reg <= cmd_word[COLOR_W-1:0];
                                fb_write_reg <= 1'b1;
                                state_reg    <= WR;
                            end
                            OP_FILL: begin
                                fb_wdata_reg <= cmd_word[COLOR_W-1:0];
                                rem_reg      <= cmd_word[12+CNT_W-1:12];
                                state_reg    <= FILL;
                            end
                            default: begin
                                if (cmd_word[0]) begin
                                    overrun_reg   <= 1'b0;
                                    range_err_reg <= 1'b0;
                                end
                            end
                        endcase
                    end
                end

                SETXY: begin
                    if (!xy_ok) begin
                        range_err_reg <= 1'b1;
                    end
                    state_reg <= IDLE;
                end

                WR: begin
                    if (!fb_waitrequest) begin
                        fb_write_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end

                default: begin
                    // First FILL cycle only arms the write (or exits on count 0).
                    if (!fb_write_reg) begin
                        if (rem_reg == '0) begin
                            state_reg <= IDLE;
                        end else begin
                            fb_write_reg <= 1'b1;
                        end
                    end else if (!fb_waitrequest) begin
                        rem_reg <= rem_reg - CNT_W'(1);
                        if (rem_reg == CNT_W'(1)) begin
                            fb_write_reg <= 1'b0;
                            state_reg    <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        status               = 8'h00;
        status[ST_BUSY]      = (state_reg != IDLE);
        status[ST_OVERRUN]   = overrun_reg;
        status[ST_RANGE_ERR] = range_err_reg;
        status[ST_ACK_TOG]   = last_tog_reg;
    end

    assign fb_write = fb_write_reg;
    assign fb_wdata = fb_wdata_reg;

endmodule
